cpu_core_param: RTL and testbench
=================================

CPU_CORE_PARAM -- requirements
Module: cpu_core_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of registers, ALU and memory data; legal only if DATA_W >= 4 + 2*log2(NUM_REGS).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the memory address and PC width; legal only if ADDR_W <= DATA_W.
REQ-003 SHALL have parameter NUM_REGS, default 4, meaning the number of general registers; legal values are powers of 2 and >= 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
i_clk  in  1  rising-edge clock.
i_rst  in  1  synchronous reset, active high.
o_mem_req  out  1  memory request.
o_mem_we  out  1  1 = write, 0 = read.
o_mem_addr  out  ADDR_W  memory address.
o_mem_wdata  out  DATA_W  memory write data.
i_mem_ready  in  1  access completes on a cycle where req and ready are both 1.
i_mem_rdata  in  DATA_W  read data, valid when ready is 1.
i_dbg_sel  in  log2(NUM_REGS)  debug register select.
o_dbg_data  out  DATA_W  contents of R[i_dbg_sel], combinational.
o_pc  out  ADDR_W  current PC.
o_halted  out  1  core is in HALT.
o_pc_wrap  out  1  one-cycle pulse when the PC increments from all-ones to 0.
o_zr, o_ng, o_pa, o_co, o_of  out  1 each  zero, negative, even-parity, carry/borrow and signed-overflow flags (registered).

Function
REQ-005 SHALL fetch an instruction word of DATA_W bits, decoded as follows: opcode = the top 4 bits; rd = the next log2(NUM_REGS) bits; rs = the next log2(NUM_REGS) bits below rd; remaining low bits ignored.
REQ-006 SHALL implement these opcodes:
- 0 NOP.
- 1 LDI rd,#imm.
- 2 LD rd,[a].
- 3 ST rs,[a].
- 4 ADD rd,rs.
- 5 SUB rd,rs.
- 6 AND.
- 7 OR.
- 8 XOR.
- 9 MOV rd,rs.
- A JMP a.
- B JZ a.
- C JC a.
- F HLT.
- Any other opcode executes as NOP.
REQ-007 SHALL fetch a second operand word for opcodes 1, 2, 3, A, B and C; an operand used as an address takes its low ADDR_W bits.
REQ-008 SHALL implement the FSM states FETCH, DECODE, OPERAND, MEM, EXEC and HALT.
REQ-009 SHALL use these FSM transitions:
- FETCH to DECODE on handshake, capturing the IR and incrementing the PC.
- DECODE to OPERAND for operand opcodes; to EXEC for opcodes 4-9; to HALT for F; to FETCH otherwise.
- OPERAND to FETCH on handshake for LDI and jumps; to MEM for LD and ST.
- MEM to FETCH on handshake.
- EXEC to FETCH.
- HALT to HALT.
REQ-010 SHALL increment the PC on every instruction or operand fetch handshake; a taken jump loads the operand address in place of that increment.
REQ-011 SHALL take a jump when it is JMP, when it is JZ and o_zr=1, or when it is JC and o_co=1; an untaken jump falls through to PC+1.
REQ-012 SHALL wrap the PC modulo 2^ADDR_W and pulse o_pc_wrap for exactly the cycle after the wrapping increment.
REQ-013 SHALL hold o_mem_req high, with addr, we and wdata stable, from assertion until the handshake, deasserting it the cycle after; no state or PC change occurs while waiting.
REQ-014 SHALL assert o_mem_we only in the MEM state for ST, with wdata = R[rs].
REQ-015 SHALL keep o_mem_req low in DECODE, EXEC and HALT.
REQ-016 SHALL write LD and LDI data to R[rd] on the handshake; LD, LDI, MOV and jumps leave the flags unchanged.
REQ-017 SHALL update all flags from the DATA_W-bit result in EXEC for opcodes 4-8:
- zr = (result == 0).
- ng = result MSB.
- pa = even parity of the result.
- ADD: co = carry out; of = signed overflow.
- SUB (rd - rs): co = borrow, i.e. 1 when rd < rs unsigned; of = signed overflow.
- AND, OR, XOR: co = 0, of = 0.
REQ-018 SHALL complete instructions in the following cycle counts with zero-wait memory:
- ALU ops and MOV: 3.
- NOP and unknown opcodes: 2.
- LDI and jumps: 3.
- LD and ST: 4.
- Each wait cycle adds one cycle.
REQ-019 SHALL remain in HALT with o_halted=1 until reset, with no further memory requests.

Reset
REQ-020 SHALL, on the first edge where i_rst=1, apply the following reset values:
- PC, IR, every R[i] and every flag become 0.
- The state becomes FETCH.
- o_mem_req, o_mem_we, o_halted and o_pc_wrap become 0.
REQ-021 SHALL abandon any outstanding request when reset is asserted mid-access, even with i_mem_ready=0, so that o_mem_req=0 from the next cycle.
REQ-022 SHALL assert o_mem_req with o_mem_addr=0 on the first cycle after i_rst falls.

Verification (DATA_W=8, ADDR_W=8, NUM_REGS=4, encoding op<<4|rd<<2|rs)
REQ-023 SHALL be covered by a bench scenario: i_rst high for 2 cycles, then low -> o_pc=0, all flags 0, o_mem_req=1 with addr 0x00 on the first cycle after reset.
REQ-024 SHALL be covered by a bench scenario: memory 10 7F 14 01 41 -> R0=0x80, o_ng=1, o_of=1, o_co=0, o_zr=0, o_pa=0; the ADD takes 3 cycles.
REQ-025 SHALL be covered by a bench scenario: SUB R0,R0 (0x50) then JZ 0x20 (B0 20) -> o_zr=1, o_co=0, next fetch address 0x20; repeating the sequence with o_zr=0 -> next fetch address is PC+1.
REQ-026 SHALL be covered by a bench scenario: ST R1,[0x40] (0x31 0x40) with i_mem_ready held low 3 cycles in MEM -> req, we=1, addr 0x40 and wdata=R1 stable for 4 cycles; then LD R2,[0x40] -> R2 equals the stored value.
REQ-027 SHALL be covered by a bench scenario: JMP 0xFF with NOP at 0xFF -> PC goes 0xFF to 0x00 and o_pc_wrap is high for exactly one cycle.
REQ-028 SHALL be covered by a bench scenario: HLT (0xF0) -> o_halted=1 and no req for 20 cycles; separately, i_rst in OPERAND with i_mem_ready=0 -> o_mem_req=0 next cycle, o_pc=0.

Source files
------------

// File: rtl/cpu_core_param.sv
// Small parameterised accumulator-style CPU: fetch/decode/operand/mem/exec FSM
// around a register file, with a single request/ready memory port.
module cpu_core_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic                        i_mem_ready,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    input  logic [$clog2(NUM_REGS)-1:0] i_dbg_sel,
    output logic [DATA_W-1:0]           o_dbg_data,
    output logic [ADDR_W-1:0]           o_pc,
    output logic                        o_halted,
    output logic                        o_pc_wrap,
    output logic                        o_zr,
    output logic                        o_ng,
    output logic                        o_pa,
    output logic                        o_co,
    output logic                        o_of
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int MSB = DATA_W - 1;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_OPERAND = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [3:0]        op;
    logic [RW-1:0]     rd;
    logic [RW-1:0]     rs;
    logic              handshake;
    logic              jump_taken;
    logic [DATA_W:0]   alu_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_co;
    logic              alu_of;

    assign op = ir[DATA_W-1 -: 4];
    assign rd = ir[DATA_W-5 -: RW];
    assign rs = ir[DATA_W-5-RW -: RW];

    // Request is gated by reset so an access in flight is dropped immediately
    // and the first fetch is presented in the very cycle reset is released.
    assign o_mem_req   = !i_rst && (state == S_FETCH || state == S_OPERAND || state == S_MEM);
    assign o_mem_we    = !i_rst && (state == S_MEM) && (op == OP_ST);
    assign o_mem_addr  = (state == S_MEM) ? addr_q : pc;
    assign o_mem_wdata = regs[rs];
    assign handshake   = o_mem_req && i_mem_ready;

    assign o_dbg_data = regs[i_dbg_sel];
    assign o_pc       = pc;
    assign o_halted   = (state == S_HALT);

    assign jump_taken = (op == OP_JMP) || (op == OP_JZ && o_zr) || (op == OP_JC && o_co);

    always_comb begin
        alu_ext = '0;
        alu_res = '0;
        alu_co  = 1'b0;
        alu_of  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_ext = {1'b0, regs[rd]} + {1'b0, regs[rs]};
                alu_res = alu_ext[DATA_W-1:0];
                alu_co  = alu_ext[DATA_W];
                alu_of  = (regs[rd][MSB] == regs[rs][MSB]) && (alu_res[MSB] != regs[rd][MSB]);
            end
            OP_SUB: begin
                // The extra top bit of the extended difference is the borrow.
                alu_ext = {1'b0, regs[rd]} - {1'b0, regs[rs]};
                alu_res = alu_ext[DATA_W-1:0];
                alu_co  = alu_ext[DATA_W];
                alu_of  = (regs[rd][MSB] != regs[rs][MSB]) && (alu_res[MSB] != regs[rd][MSB]);
            end
            OP_AND: alu_res = regs[rd] & regs[rs];
            OP_OR:  alu_res = regs[rd] | regs[rs];
            OP_XOR: alu_res = regs[rd] ^ regs[rs];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            addr_q    <= '0;
            ir        <= '0;
            o_pc_wrap <= 1'b0;
            o_zr      <= 1'b0;
            o_ng      <= 1'b0;
            o_pa      <= 1'b0;
            o_co      <= 1'b0;
            o_of      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            o_pc_wrap <= 1'b0;
            case (state)
                S_FETCH: if (handshake) begin
                    ir        <= i_mem_rdata;
                    pc        <= pc + 1'b1;
                    o_pc_wrap <= &pc;
                    state     <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_JC: state <= S_OPERAND;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: state <= S_EXEC;
                        OP_HLT: state <= S_HALT;
                        default: state <= S_FETCH;
                    endcase
                end
                S_OPERAND: if (handshake) begin
                    addr_q <= i_mem_rdata[ADDR_W-1:0];
                    if ((op == OP_JMP || op == OP_JZ || op == OP_JC) && jump_taken) begin
                        pc <= i_mem_rdata[ADDR_W-1:0];
                    end else begin
                        pc        <= pc + 1'b1;
                        o_pc_wrap <= &pc;
                    end
                    if (op == OP_LDI) regs[rd] <= i_mem_rdata;
                    state <= (op == OP_LD || op == OP_ST) ? S_MEM : S_FETCH;
                end
                S_MEM: if (handshake) begin
                    if (op == OP_LD) regs[rd] <= i_mem_rdata;
                    state <= S_FETCH;
                end
                S_EXEC: begin
                    if (op == OP_MOV) begin
                        regs[rd] <= regs[rs];
                    end else begin
                        regs[rd] <= alu_res;
                        o_zr     <= (alu_res == '0);
                        o_ng     <= alu_res[MSB];
                        o_pa     <= ~^alu_res;
                        o_co     <= alu_co;
                        o_of     <= alu_of;
                    end
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param: small programs in a behavioural memory,
// hand-computed register, flag, address and cycle-count expectations.
module tb_cpu_core_param;
    logic       clk;
    logic       rst;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic [7:0] pc;
    logic       halted;
    logic       pc_wrap;
    logic       zr, ng, pa, co, of;

    logic [7:0] mem [256];
    int checks;
    int fails;

    cpu_core_param #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .i_dbg_sel(dbg_sel), .o_dbg_data(dbg_data), .o_pc(pc), .o_halted(halted),
        .o_pc_wrap(pc_wrap), .o_zr(zr), .o_ng(ng), .o_pa(pa), .o_co(co), .o_of(of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic reset_core();
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic peek(input logic [1:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1 val = dbg_data;
    endtask

    task automatic wait_addr(input logic [7:0] a, input int budget, output int cyc);
        bit found;
        found = 0;
        cyc = 0;
        while (!found && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (mem_req && mem_addr == a) found = 1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL wait_addr: no request to %h within %0d cycles", a, budget);
        end
    endtask

    task automatic wait_halt(input int budget);
        int cyc;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!halted) begin
            fails++;
            $display("FAIL wait_halt: halted=%b after %0d cycles, expected 1", halted, budget);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req_during: got %b expected 0", mem_req); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 8'h00) begin fails++; $display("FAIL rst_pc: got %h expected 00", pc); end
        checks++;
        if ({zr, ng, pa, co, of} !== 5'b0) begin fails++; $display("FAIL rst_flags: got %b expected 00000", {zr, ng, pa, co, of}); end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
            fails++; $display("FAIL rst_first_fetch: req=%b addr=%h we=%b expected 1 00 0", mem_req, mem_addr, mem_we);
        end
        checks++;
        if (halted !== 1'b0 || pc_wrap !== 1'b0) begin fails++; $display("FAIL rst_status: halted=%b wrap=%b expected 0 0", halted, pc_wrap); end
    endtask

    task automatic test_add_overflow();
        int cyc;
        logic [7:0] v;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h7F; mem[2] = 8'h14; mem[3] = 8'h01; mem[4] = 8'h41; mem[5] = 8'hF0;
        reset_core();
        wait_addr(8'h04, 20, cyc);
        wait_addr(8'h05, 10, cyc);
        checks++;
        if (cyc !== 3) begin fails++; $display("FAIL add_cycles: got %0d expected 3", cyc); end
        wait_halt(10);
        peek(2'd0, v);
        checks++;
        if (v !== 8'h80) begin fails++; $display("FAIL add_r0: got %h expected 80", v); end
        checks++;
        if ({zr, ng, pa, co, of} !== 5'b01001) begin fails++; $display("FAIL add_flags: got %b expected 01001", {zr, ng, pa, co, of}); end
    endtask

    task automatic test_jz();
        int cyc;
        logic [7:0] v;
        clear_mem();
        mem[8'h00] = 8'h50; mem[8'h01] = 8'hB0; mem[8'h02] = 8'h20;
        mem[8'h20] = 8'h14; mem[8'h21] = 8'h05; mem[8'h22] = 8'h54;
        mem[8'h23] = 8'hB0; mem[8'h24] = 8'h20; mem[8'h25] = 8'hF0;
        reset_core();
        wait_addr(8'h01, 10, cyc);
        checks++;
        if (zr !== 1'b1 || co !== 1'b0) begin fails++; $display("FAIL jz_sub_flags: zr=%b co=%b expected 1 0", zr, co); end
        wait_addr(8'h02, 10, cyc);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h20 || pc !== 8'h20) begin
            fails++; $display("FAIL jz_taken: req=%b addr=%h pc=%h expected 1 20 20", mem_req, mem_addr, pc);
        end
        wait_addr(8'h23, 20, cyc);
        checks++;
        if (zr !== 1'b0) begin fails++; $display("FAIL jz_nz_flag: zr=%b expected 0", zr); end
        wait_addr(8'h24, 10, cyc);
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h25 || pc !== 8'h25) begin fails++; $display("FAIL jz_not_taken: addr=%h pc=%h expected 25 25", mem_addr, pc); end
        wait_halt(10);
        peek(2'd1, v);
        checks++;
        if (v !== 8'h05) begin fails++; $display("FAIL jz_r1: got %h expected 05", v); end
    endtask

    task automatic test_logic_borrow();
        logic [7:0] v;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h0F; mem[2] = 8'h14; mem[3] = 8'h3C;
        mem[4] = 8'h61; mem[5] = 8'h9C; mem[6] = 8'h8C; mem[7] = 8'h5D;
        mem[8] = 8'hC0; mem[9] = 8'h30; mem[10] = 8'hF0; mem[8'h30] = 8'hF0;
        reset_core();
        wait_halt(60);
        peek(2'd0, v);
        checks++;
        if (v !== 8'h0C) begin fails++; $display("FAIL logic_r0_and: got %h expected 0C", v); end
        peek(2'd3, v);
        checks++;
        if (v !== 8'hC4) begin fails++; $display("FAIL logic_r3_sub: got %h expected C4", v); end
        checks++;
        if ({zr, ng, pa, co, of} !== 5'b01010) begin fails++; $display("FAIL logic_sub_flags: got %b expected 01010", {zr, ng, pa, co, of}); end
        checks++;
        if (pc !== 8'h31) begin fails++; $display("FAIL logic_jc_pc: got %h expected 31", pc); end
    endtask

    task automatic test_st_ld_wait();
        int cyc;
        logic [7:0] v;
        clear_mem();
        mem[0] = 8'h14; mem[1] = 8'hA5; mem[2] = 8'h31; mem[3] = 8'h40;
        mem[4] = 8'h28; mem[5] = 8'h40; mem[6] = 8'hF0;
        reset_core();
        wait_addr(8'h03, 20, cyc);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'hA5 || pc !== 8'h04) begin
                fails++;
                $display("FAIL st_hold[%0d]: req=%b we=%b addr=%h wdata=%h pc=%h expected 1 1 40 A5 04",
                         i, mem_req, mem_we, mem_addr, mem_wdata, pc);
            end
            if (i == 2) begin
                @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        end
        wait_addr(8'h04, 2, cyc);
        wait_addr(8'h06, 10, cyc);
        checks++;
        if (cyc !== 4) begin fails++; $display("FAIL ld_cycles: got %0d expected 4", cyc); end
        wait_halt(10);
        peek(2'd2, v);
        checks++;
        if (v !== 8'hA5) begin fails++; $display("FAIL ld_r2: got %h expected A5", v); end
        checks++;
        if (mem[8'h40] !== 8'hA5) begin fails++; $display("FAIL st_mem: got %h expected A5", mem[8'h40]); end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        clear_mem();
        mem[8'h00] = 8'hA0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h00;
        reset_core();
        wait_addr(8'hFF, 10, cyc);
        checks++;
        if (pc !== 8'hFF || pc_wrap !== 1'b0) begin fails++; $display("FAIL wrap_before: pc=%h wrap=%b expected FF 0", pc, pc_wrap); end
        @(negedge clk);
        checks++;
        if (pc !== 8'h00 || pc_wrap !== 1'b1) begin fails++; $display("FAIL wrap_pulse: pc=%h wrap=%b expected 00 1", pc, pc_wrap); end
        @(negedge clk);
        checks++;
        if (pc_wrap !== 1'b0 || mem_addr !== 8'h00 || mem_req !== 1'b1) begin
            fails++; $display("FAIL wrap_after: wrap=%b addr=%h req=%b expected 0 00 1", pc_wrap, mem_addr, mem_req);
        end
        // NOP at FF is two cycles fetch-to-fetch
        checks++;
        if (cyc === 0) begin fails++; $display("FAIL wrap_reach: got %0d cycles expected nonzero", cyc); end
        wait_addr(8'hFF, 10, cyc);
        wait_addr(8'h00, 10, cyc);
        checks++;
        if (cyc !== 2) begin fails++; $display("FAIL nop_cycles: got %0d expected 2", cyc); end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[0] = 8'hF0;
        reset_core();
        wait_halt(10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || halted !== 1'b1) begin
                fails++; $display("FAIL halt_idle[%0d]: req=%b halted=%b expected 0 1", i, mem_req, halted);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc;
        clear_mem();
        mem[0] = 8'h14; mem[1] = 8'h33;
        reset_core();
        wait_addr(8'h01, 10, cyc);
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01 || pc !== 8'h01) begin
            fails++; $display("FAIL stall_hold: req=%b addr=%h pc=%h expected 1 01 01", mem_req, mem_addr, pc);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00) begin fails++; $display("FAIL rst_mid: req=%b pc=%h expected 0 00", mem_req, pc); end
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin fails++; $display("FAIL rst_mid_restart: req=%b addr=%h expected 1 00", mem_req, mem_addr); end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        mem_ready = 1'b1;
        dbg_sel = 2'd0;
        test_reset();
        test_add_overflow();
        test_jz();
        test_logic_borrow();
        test_st_ld_wait();
        test_pc_wrap();
        test_halt();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
